// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, flag vector type and add/sub opcode encoding.
package alu_pkg;

    localparam int unsigned FLAG_Z    = 0;
    localparam int unsigned FLAG_C    = 1;
    localparam int unsigned FLAG_S    = 2;
    localparam int unsigned FLAG_V    = 3;
    localparam int unsigned NUM_FLAGS = 4;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } op_e;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CW-bit adder slice with carry in/out; one instance per pipeline stage.
module addsub_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract, one carry-chained chunk per stage, with flags and tag.
// Optional signed saturation in the final stage when ADDSUB_SAT_EN is defined.
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [TAG_W-1:0] out_tag,
    output logic             z_flag,
    output logic             carry_flag,
    output logic             sign_flag,
    output logic             overflow_flag
);

    localparam int CW        = WIDTH / STAGES;
    localparam int CHUNK_TOP = (STAGES - 1) * CW;

    logic              en;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] cy_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];

    logic [WIDTH-1:0]  sum_w;
    logic [STAGES-1:0] cout_w;

    logic [WIDTH-1:0]  res_d;
    logic [WIDTH-1:0]  c_d;
    logic              ovf_d;
    flags_t            flags_d;

    logic              out_valid_q;
    logic [WIDTH-1:0]  c_q;
    logic [TAG_W-1:0]  out_tag_q;
    flags_t            flags_q;

    assign en = ~out_valid_q | out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        addsub_chunk #(.CW(CW)) u_chunk (
            .a    (a_q[k][k*CW +: CW]),
            .b    (b_q[k][k*CW +: CW]),
            .cin  (cy_q[k]),
            .sum  (sum_w[k*CW +: CW]),
            .cout (cout_w[k])
        );
    end

    // Level k holds operands plus chunks 0..k-1 of the sum; the output register is level STAGES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q         <= '0;
            cy_q        <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                tag_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            c_q         <= '0;
            out_tag_q   <= '0;
            flags_q     <= '0;
        end else if (en) begin
            v_q[0]   <= in_valid;
            a_q[0]   <= a;
            b_q[0]   <= (add_sub == SUB) ? ~b : b;
            cy_q[0]  <= add_sub;
            s_q[0]   <= '0;
            tag_q[0] <= in_tag;
            for (int unsigned k = 0; k + 1 < STAGES; k++) begin
                v_q[k+1]                <= v_q[k];
                a_q[k+1]                <= a_q[k];
                b_q[k+1]                <= b_q[k];
                tag_q[k+1]              <= tag_q[k];
                cy_q[k+1]               <= cout_w[k];
                s_q[k+1]                <= s_q[k];
                s_q[k+1][k*CW +: CW]    <= sum_w[k*CW +: CW];
            end
            out_valid_q <= v_q[STAGES-1];
            c_q         <= c_d;
            out_tag_q   <= tag_q[STAGES-1];
            flags_q     <= flags_d;
        end
    end

    always_comb begin
        res_d                   = s_q[STAGES-1];
        res_d[CHUNK_TOP +: CW]  = sum_w[CHUNK_TOP +: CW];
        ovf_d = ( a_q[STAGES-1][WIDTH-1] &  b_q[STAGES-1][WIDTH-1] & ~res_d[WIDTH-1]) |
                (~a_q[STAGES-1][WIDTH-1] & ~b_q[STAGES-1][WIDTH-1] &  res_d[WIDTH-1]);
        c_d   = res_d;
`ifdef ADDSUB_SAT_EN
        if (ovf_d) begin
            c_d = a_q[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        flags_d         = '0;
        flags_d[FLAG_Z] = ~|c_d;
        flags_d[FLAG_C] = cout_w[STAGES-1];
        flags_d[FLAG_S] = c_d[WIDTH-1];
        flags_d[FLAG_V] = ovf_d;
    end

    assign in_ready      = en;
    assign out_valid     = out_valid_q;
    assign c             = c_q;
    assign out_tag       = out_tag_q;
    assign z_flag        = flags_q[FLAG_Z];
    assign carry_flag    = flags_q[FLAG_C];
    assign sign_flag     = flags_q[FLAG_S];
    assign overflow_flag = flags_q[FLAG_V];

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined integer add/subtract unit; next-generation replacement for the single-cycle 32-bit ALU adder.
- Splits the WIDTH-bit operation into STAGES carry-chained chunks, one chunk per pipeline stage, so wide adds close timing.
- Produces result plus zero/carry/sign/overflow flags with a valid/ready handshake and a pass-through tag.
- Sits between the operand-fetch stage and the ALU result mux.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of STAGES.
STAGES, 4, pipeline depth and chunk count; 1..WIDTH; chunk width CW = WIDTH/STAGES.
TAG_W, 4, width of the opaque tag carried alongside each operation; must be >= 1.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  operation offered.
in_ready  output  1  unit accepts operation this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
add_sub  input  1  0 = a+b; 1 = a-b, computed as a + ~b + 1.
in_tag  input  TAG_W  tag, returned unchanged with the result.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
c  output  WIDTH  result.
out_tag  output  TAG_W  tag of the result.
z_flag  output  1  c == 0.
carry_flag  output  1  raw carry out of MSB; for subtract, 1 = no borrow.
sign_flag  output  1  c[WIDTH-1].
overflow_flag  output  1  signed overflow.

Behaviour:
- Reset (asynchronous): every stage valid bit, out_valid, c, out_tag and all flags go to 0. in_ready = 1 once reset deasserts. Reset mid-stream discards all in-flight operations; no partial result ever appears.
- Global pipeline enable: en = !out_valid | out_ready. in_ready = en. The transfer occurs on in_valid & in_ready. All stages advance together when en = 1 and hold when en = 0.
- Stage 0 registers a, Bop = add_sub ? ~b : b, cin = add_sub, tag and valid.
- Stage k (0..STAGES-1) adds chunk k of a and Bop, bits [k*CW +: CW], with the carry registered from stage k-1 (cin for k=0).
  - Completed low chunks are skewed forward unchanged.
  - Unused high operand chunks travel forward delayed.
- Latency: accepted on edge N gives out_valid = 1 after edge N+STAGES. With STAGES=1, the result is registered one cycle after acceptance.
- Throughput: one operation per cycle when out_ready is held high. Bubbles (in_valid = 0) propagate as invalid slots. Order is always preserved.
- Flags are computed from the final-stage full result:
  - z_flag = ~|c
  - carry_flag = carry out of the top chunk
  - sign_flag = c[WIDTH-1]
  - overflow_flag = (a_msb & Bop_msb & ~c_msb) | (~a_msb & ~Bop_msb & c_msb)
- The output holds c, the flags and out_tag stable while out_valid & ~out_ready.
- in_valid = 1 while in_ready = 0: nothing is captured; the upstream holds.
- Simultaneous accept and output handshake in the same cycle is legal and required at full rate.

Optional Feature:
- Macro ADDSUB_SAT_EN enables signed saturation.
  - Defined: when the overflow condition is true, c = 0x7F..F if a_msb = 0, else 0x80..0. overflow_flag = 1 (reports that saturation happened). z_flag and sign_flag follow the saturated c. carry_flag is unchanged (raw carry). Latency is unchanged; the saturation mux sits in the final stage.
  - Undefined: wrap-around result, and no saturation logic is generated.

Decomposition:
- Shared package alu_pkg holds:
  - flag bit-index constants FLAG_Z=0, FLAG_C=1, FLAG_S=2, FLAG_V=3, and a 4-bit flag vector typedef;
  - the ADD=0/SUB=1 encoding constants for add_sub.
- Sub-module addsub_chunk: a combinational CW-bit adder (a, b, cin -> sum, cout); STAGES instances are created by generate.

Test Plan (WIDTH=32, STAGES=4 unless stated):
- 0x7FFFFFFF + 0x00000001, out_ready=1 -> after 4 cycles c=0x80000000, V=1, S=1, C=0, Z=0, tag echoed.
- 5 - 5 (add_sub=1) -> c=0, Z=1, C=1, V=0; 0xFFFFFFFF + 1 -> c=0, C=1, Z=1, V=0; 3 - 5 -> c=0xFFFFFFFE, C=0, S=1.
- 8 back-to-back ops with tags 0..7 and out_ready low on cycles 6-8 -> in_ready low exactly while out_valid & ~out_ready; all 8 results arrive in tag order; none lost or duplicated.
- Reset asserted with 3 ops in flight -> out_valid drops immediately; no stale result after release; next op has 4-cycle latency.
- With ADDSUB_SAT_EN: 0x7FFFFFFF + 1 -> c=0x7FFFFFFF, V=1; 0x80000000 - 1 -> c=0x80000000, V=1, S=1.
- STAGES=1 and STAGES=32 builds: random 10k ops vs reference model -> bit-exact c and flags, latency = STAGES.
